// File: rtl/dp_tap_ctrl_if.sv
// JTAG serial port plus boundary-scan cell control bundle for dp_tap_ctrl.
// master = TAP host / cell chain side, slave = the TAP controller itself.
interface dp_tap_ctrl_if #(
    parameter int IR_W = 4
);
    logic            tck_en;
    logic            tms;
    logic            tdi;
    logic            tdo;
    logic            tdo_en;
    logic            bsc_sin;
    logic            bsc_sout;
    logic            shift_dr;
    logic            clk_dr;
    logic            update_dr;
    logic            mode;
    logic [IR_W-1:0] ir_out;

    modport master (
        output tck_en, tms, tdi, bsc_sout,
        input  tdo, tdo_en, bsc_sin, shift_dr, clk_dr, update_dr, mode, ir_out
    );

    modport slave (
        input  tck_en, tms, tdi, bsc_sout,
        output tdo, tdo_en, bsc_sin, shift_dr, clk_dr, update_dr, mode, ir_out
    );
endinterface

// File: rtl/dp_tap_ctrl.sv
// 1149.1-style TAP controller clocked by the system clock. TCK rising edges
// arrive as a one-cycle tck_en strobe; every state element only moves on it.
// Drives a boundary-scan cell chain (shift_dr/clk_dr/update_dr/mode) and
// hosts the IR, BYPASS and IDCODE registers. IDCODE_VAL[0] must be 1.
module dp_tap_ctrl #(
    parameter int          IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5679
) (
    input logic          iclk,
    input logic          resetn,
    dp_tap_ctrl_if.slave tap
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_e;

    localparam logic [IR_W-1:0] IR_EXTEST = '0;
    localparam logic [IR_W-1:0] IR_SAMPLE = IR_W'(1);
    localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(2);

    tap_state_e      state, nxt;
    logic [IR_W-1:0] ir, ir_nxt, ir_sr;
    logic [31:0]     id_sr;
    logic            byp;
    logic            tdo_q, tdo_en_q, shift_dr_q, mode_q;
    logic            ir_bsc, ir_id;

    // EXTEST and SAMPLE/PRELOAD hand the DR path to the external cells.
    function automatic logic is_bsc(input logic [IR_W-1:0] code);
        return (code == IR_EXTEST) || (code == IR_SAMPLE);
    endfunction

    assign ir_bsc = is_bsc(ir);
    assign ir_id  = (ir == IR_IDCODE);

    // Standard 16-state successor selected by tms.
    always_comb begin
        nxt = state;
        unique case (state)
            TLR:      nxt = tap.tms ? TLR    : RTI;
            RTI:      nxt = tap.tms ? SEL_DR : RTI;
            SEL_DR:   nxt = tap.tms ? SEL_IR : CAP_DR;
            CAP_DR:   nxt = tap.tms ? EX1_DR : SH_DR;
            SH_DR:    nxt = tap.tms ? EX1_DR : SH_DR;
            EX1_DR:   nxt = tap.tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: nxt = tap.tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   nxt = tap.tms ? UPD_DR : SH_DR;
            UPD_DR:   nxt = tap.tms ? SEL_DR : RTI;
            SEL_IR:   nxt = tap.tms ? TLR    : CAP_IR;
            CAP_IR:   nxt = tap.tms ? EX1_IR : SH_IR;
            SH_IR:    nxt = tap.tms ? EX1_IR : SH_IR;
            EX1_IR:   nxt = tap.tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: nxt = tap.tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   nxt = tap.tms ? UPD_IR : SH_IR;
            UPD_IR:   nxt = tap.tms ? SEL_DR : RTI;
            default:  nxt = TLR;
        endcase
    end

    // Active instruction after this strobe. Forcing IDCODE on the edge that
    // enters TLR (not only while sitting in it) means five tms=1 strobes leave
    // the IR already reset, with no extra strobe needed.
    always_comb begin
        ir_nxt = ir;
        if (state == UPD_IR)
            ir_nxt = ir_sr;
        if (state == TLR || nxt == TLR)
            ir_nxt = IR_IDCODE;
    end

    // TAP FSM, IR/DR shift paths and registered decodes, all gated by tck_en.
    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            state      <= TLR;
            ir         <= IR_IDCODE;
            ir_sr      <= '0;
            id_sr      <= '0;
            byp        <= 1'b0;
            tdo_q      <= 1'b0;
            tdo_en_q   <= 1'b0;
            shift_dr_q <= 1'b0;
            mode_q     <= 1'b0;
        end else if (tap.tck_en) begin
            state      <= nxt;
            ir         <= ir_nxt;
            // Level outputs track the post-edge state/IR so they line up with
            // the registers they describe.
            tdo_en_q   <= (nxt == SH_DR) || (nxt == SH_IR);
            shift_dr_q <= (nxt == SH_DR) && is_bsc(ir_nxt);
            mode_q     <= (ir_nxt == IR_EXTEST);
            case (state)
                CAP_IR: ir_sr <= IR_W'(1);
                SH_IR: begin
                    tdo_q <= ir_sr[0];
                    ir_sr <= {tap.tdi, ir_sr[IR_W-1:1]};
                end
                CAP_DR: begin
                    // Boundary cells capture on their own via clk_dr.
                    if (ir_id)
                        id_sr <= IDCODE_VAL;
                    else if (!ir_bsc)
                        byp <= 1'b0;
                end
                SH_DR: begin
                    if (ir_bsc) begin
                        // Last cell's pre-edge bit; the cells shift on this
                        // same edge through clk_dr.
                        tdo_q <= tap.bsc_sout;
                    end else if (ir_id) begin
                        tdo_q <= id_sr[0];
                        id_sr <= {tap.tdi, id_sr[31:1]};
                    end else begin
                        tdo_q <= byp;
                        byp   <= tap.tdi;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tap.tdo       = tdo_q;
    assign tap.tdo_en    = tdo_en_q;
    assign tap.shift_dr  = shift_dr_q;
    assign tap.mode      = mode_q;
    assign tap.ir_out    = ir;
    assign tap.bsc_sin   = tap.tdi;
    // Strobes are combinational so they sit inside the tck_en cycle itself.
    assign tap.clk_dr    = tap.tck_en && ir_bsc && (state == CAP_DR || state == SH_DR);
    assign tap.update_dr = tap.tck_en && ir_bsc && (state == UPD_DR);

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// Directed bench for dp_tap_ctrl: IDCODE/BYPASS/IR shifts, boundary strobes
// against a 4-cell chain model, 5x tms=1 reset and async reset mid-shift.
module tb_dp_tap_ctrl;

    logic iclk;
    logic resetn;
    int   n_chk, n_pass;
    int   n_clk, n_upd, n_sh;
    logic [3:0] chain;
    logic [3:0] d;
    logic [31:0] got;

    dp_tap_ctrl_if #(.IR_W(4)) bus();

    dp_tap_ctrl #(.IR_W(4), .IDCODE_VAL(32'h1234_5679)) dut (
        .iclk   (iclk),
        .resetn (resetn),
        .tap    (bus.slave)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Boundary chain model: capture 4'b1010, shift tdi in at the top.
    always @(posedge iclk or negedge resetn) begin
        if (!resetn)
            chain <= 4'b0000;
        else if (bus.clk_dr)
            chain <= bus.shift_dr ? {bus.bsc_sin, chain[3:1]} : 4'b1010;
    end
    assign bus.bsc_sout = chain[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h exp %h", tag, obs, exp);
    endtask

    // One TCK strobe; strobes are sampled mid-cycle, before the active edge.
    task automatic tck(input logic t, input logic di);
        @(negedge iclk);
        bus.tms = t; bus.tdi = di; bus.tck_en = 1'b1;
        #2;
        if (bus.clk_dr)    n_clk++;
        if (bus.update_dr) n_upd++;
        if (bus.shift_dr)  n_sh++;
        @(negedge iclk);
        bus.tck_en = 1'b0;
    endtask

    // RTI -> load IR -> RTI, returning the bits seen on tdo while shifting.
    task automatic load_ir(input logic [3:0] val, output logic [3:0] cap);
        cap = '0;
        tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        for (int i = 0; i < 4; i++) begin
            tck(i == 3, val[i]);
            cap[i] = bus.tdo;
        end
        tck(1, 0); tck(0, 0);
    endtask

    // RTI -> shift n DR bits -> UPDATE_DR -> RTI.
    task automatic dr_shift(input logic [3:0] din, input int n, output logic [3:0] dout);
        dout = '0;
        tck(1, 0); tck(0, 0); tck(0, 0);
        for (int i = 0; i < n; i++) begin
            tck(i == n - 1, din[i]);
            dout[i] = bus.tdo;
        end
        tck(1, 0); tck(0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_pass = 0; n_clk = 0; n_upd = 0; n_sh = 0;
        bus.tck_en = 1'b0; bus.tms = 1'b0; bus.tdi = 1'b0;
        resetn = 1'b0;
        repeat (3) @(negedge iclk);
        chk("rst_tdo",    32'(bus.tdo),       0);
        chk("rst_tdo_en", 32'(bus.tdo_en),    0);
        chk("rst_shdr",   32'(bus.shift_dr),  0);
        chk("rst_mode",   32'(bus.mode),      0);
        chk("rst_ir",     32'(bus.ir_out),    2);
        chk("rst_clkdr",  32'(bus.clk_dr),    0);
        chk("rst_upddr",  32'(bus.update_dr), 0);
        resetn = 1'b1;

        // IDCODE read straight out of reset
        tck(0, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        chk("id_tdo_en", 32'(bus.tdo_en), 1);
        n_clk = 0; n_sh = 0;
        for (int i = 0; i < 32; i++) begin
            tck(0, 0);
            got[i] = bus.tdo;
        end
        chk("id_value", got, 32'h1234_5679);
        chk("id_clkdr", 32'(n_clk), 0);
        chk("id_shdr",  32'(n_sh), 0);
        tck(1, 0); tck(1, 0); tck(0, 0);
        chk("id_exit_tdo_en", 32'(bus.tdo_en), 0);

        // BYPASS via all-ones, captured IR pattern 0001
        load_ir(4'hF, d);
        chk("ir_cap_f", 32'(d), 32'b0001);
        chk("ir_f",     32'(bus.ir_out), 32'hF);
        chk("mode_f",   32'(bus.mode), 0);
        dr_shift(4'b1101, 4, d);
        chk("byp_tdo",  32'(d), 32'b1010);

        // unassigned code also acts as BYPASS
        load_ir(4'h5, d);
        chk("ir_5", 32'(bus.ir_out), 5);
        dr_shift(4'b0011, 2, d);
        chk("byp5_tdo", 32'(d), 32'b0010);

        // EXTEST with boundary strobes
        load_ir(4'h0, d);
        chk("ir_cap_0", 32'(d), 32'b0001);
        chk("ir_0",     32'(bus.ir_out), 0);
        chk("mode_ext", 32'(bus.mode), 1);
        n_clk = 0; n_upd = 0; n_sh = 0;
        dr_shift(4'b0101, 3, d);
        chk("bsc_tdo",  32'(d), 32'b0010);
        chk("bsc_clk",  32'(n_clk), 4);
        chk("bsc_sh",   32'(n_sh), 3);
        chk("bsc_upd",  32'(n_upd), 1);
        @(negedge iclk); bus.tdi = 1'b1; #1;
        chk("bsc_sin1", 32'(bus.bsc_sin), 1);
        bus.tdi = 1'b0; #1;
        chk("bsc_sin0", 32'(bus.bsc_sin), 0);

        // five tms=1 from SHIFT_DR under EXTEST
        tck(1, 0); tck(0, 0); tck(0, 0);
        chk("tlr_pre_shdr", 32'(bus.shift_dr), 1);
        repeat (5) tck(1, 0);
        chk("tlr_ir",     32'(bus.ir_out), 2);
        chk("tlr_mode",   32'(bus.mode), 0);
        chk("tlr_tdo_en", 32'(bus.tdo_en), 0);
        chk("tlr_shdr",   32'(bus.shift_dr), 0);
        tck(0, 0);
        dr_shift(4'b0000, 1, d);
        chk("tlr_id_bit0", 32'(d), 32'b0001);

        // async reset two bits into SHIFT_IR
        load_ir(4'h0, d);
        tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        tck(0, 1); tck(0, 1);
        chk("mid_tdo_en", 32'(bus.tdo_en), 1);
        chk("mid_mode",   32'(bus.mode), 1);
        @(posedge iclk); #2;
        resetn = 1'b0;
        #1;
        chk("ar_ir",     32'(bus.ir_out), 2);
        chk("ar_tdo",    32'(bus.tdo), 0);
        chk("ar_tdo_en", 32'(bus.tdo_en), 0);
        chk("ar_mode",   32'(bus.mode), 0);
        @(negedge iclk);
        resetn = 1'b1;
        n_clk = 0; n_upd = 0;
        repeat (3) tck(0, 0);
        chk("ar_no_clk", 32'(n_clk), 0);
        chk("ar_no_upd", 32'(n_upd), 0);
        chk("ar_ir_kept", 32'(bus.ir_out), 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dp_tap_ctrl.md
Name: dp_tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller running in the system clock domain.
- Decodes the serial JTAG stream (tms/tdi/tdo, qualified by a one-cycle tck_en strobe) into the control signals that drive a chain of debug boundary scan cells: shift_dr, clk_dr, update_dr and mode.
- Provides the instruction register, the bypass register and the IDCODE register, and selects which register drives tdo.

Parameters:
- IR_W, 4, instruction register width (>= 2).
- IDCODE_VAL, 32'h1234_5679, value captured in IDCODE; bit 0 must be 1.

Ports:
- iclk  input  1  system clock; all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- tck_en  input  1  one-iclk-cycle strobe marking a TCK rising edge (already synchronized); all TAP activity is gated by it.
- tms  input  1  test mode select, sampled when tck_en=1.
- tdi  input  1  test data in, sampled when tck_en=1.
- tdo  output  1  test data out, registered.
- tdo_en  output  1  high while in SHIFT_DR or SHIFT_IR.
- bsc_sin  output  1  serial input to the first boundary cell; equals tdi (combinational).
- bsc_sout  input  1  serial output of the last boundary cell.
- shift_dr  output  1  level: state==SHIFT_DR and a boundary instruction is active.
- clk_dr  output  1  one-cycle pulse: tck_en & (CAPTURE_DR|SHIFT_DR) & boundary instruction.
- update_dr  output  1  one-cycle pulse: tck_en & UPDATE_DR & boundary instruction.
- mode  output  1  1 while the active instruction is EXTEST.
- ir_out  output  IR_W  active instruction.

Behaviour:
- Reset (resetn=0, async):
  - state = TEST_LOGIC_RESET.
  - active IR = IDCODE (2).
  - IR shift register = 0, bypass = 0, IDCODE shift register = 0.
  - tdo = 0; tdo_en, shift_dr, clk_dr, update_dr and mode all 0.
- State machine: the standard 16-state TAP. Transitions occur only on iclk edges where tck_en=1, and tms selects the successor exactly per 1149.1. With tck_en=0 all registers hold.
- In TEST_LOGIC_RESET, active IR is forced to IDCODE every tck_en.
- Five consecutive tck_en with tms=1 reach TEST_LOGIC_RESET from any state.
- Instruction decode:
  - 0 = EXTEST.
  - 1 = SAMPLE/PRELOAD.
  - 2 = IDCODE.
  - All-ones = BYPASS.
  - Every other code decodes as BYPASS.
  - Boundary instructions are EXTEST and SAMPLE/PRELOAD.
- IR path (each on a tck_en edge):
  - CAPTURE_IR: IR shift register <= {0..., 2'b01}.
  - SHIFT_IR: tdo <= shift register bit 0; shift register <= {tdi, sr[IR_W-1:1]}.
  - UPDATE_IR: active IR <= shift register.
- DR path, selected by the active IR (each on a tck_en edge):
  - BYPASS:
    - CAPTURE_DR: bypass <= 0.
    - SHIFT_DR: tdo <= bypass; bypass <= tdi.
  - IDCODE:
    - CAPTURE_DR: idcode_sr <= IDCODE_VAL.
    - SHIFT_DR: tdo <= idcode_sr[0]; idcode_sr shifts right with tdi into bit 31.
  - Boundary instructions:
    - SHIFT_DR: tdo <= bsc_sout, i.e. the last cell's pre-edge value. This is correct because the cells capture on the same edge through clk_dr.
    - Capture and shift are performed by the cells themselves via clk_dr/shift_dr.
- Timing:
  - tdo changes only on tck_en edges while in a shift state and otherwise holds.
  - The first valid tdo bit appears one iclk cycle after the tck_en edge that enters/shifts within SHIFT_xR.
  - tdo_en, shift_dr and mode are decoded from the registered state/IR, so they change one cycle after the causing edge.
  - clk_dr and update_dr are combinational from tck_en and the registered state, and are high only in tck_en cycles.
  - update_dr and the active-IR change are never both asserted: UPDATE_IR and UPDATE_DR are exclusive states.
- Mode ownership: mode changes only at UPDATE_IR or on reset. A SAMPLE to EXTEST switch takes effect at the tck_en edge in UPDATE_IR.
- Async reset mid-shift: aborts immediately and all outputs return to reset values. A partially shifted IR is never applied.

Test Plan:
- Reset, then tms 0,1,0,0 (RTI→SELECT_DR→CAPTURE_DR→SHIFT_DR), then 32 shifts with tdi=0 → tdo bits LSB-first = 32'h1234_5679; shift_dr=0 and clk_dr never pulses.
- Load IR=4'hF (BYPASS) and shift DR pattern 1,0,1,1 → tdo = 0,1,0,1 (one-bit delay, first bit is the captured 0).
- Enter SHIFT_IR with tdi=0 → first 4 tdo bits = 1,0,0,0 (captured 4'b0001); after UPDATE_IR, ir_out = the shifted value.
- Load IR=0 (EXTEST) → mode=1. Pass CAPTURE_DR→SHIFT_DR×3→UPDATE_DR → clk_dr pulses 4 times, shift_dr=1 for exactly the 3 shift tck_en cycles, update_dr pulses once, bsc_sin follows tdi, tdo follows the model bsc_sout.
- From SHIFT_DR with EXTEST active, apply tms=1 for 5 tck_en → state TEST_LOGIC_RESET, ir_out=2, mode=0.
- Drop resetn mid-SHIFT_IR after 2 of 4 bits → immediate reset values, ir_out=2, tdo=0, and no update_dr/clk_dr pulses afterwards until a new sequence.
